divider: RTL
============

# divider

Multi-cycle integer divider for the execute stage, sitting beside `alu` on the same operand and result paths. The microsequencer starts it for DIVU and DIV, 8- and 16-bit. It uses a radix-2 restoring algorithm, takes one quotient bit per cycle, and produces a quotient, a remainder, and a divide-error indication. The microsequencer stalls on `busy`, writes AW/DW (or AL/AH) on `done`, and vectors to INT 0 on `div_error`.

## Interface
- No parameters.
- `clk` — input, 1 bit. Core clock; one clock domain.
- `reset` — input, 1 bit. Synchronous, active-high.
- `start` — input, 1 bit. Request; sampled only in IDLE.
- `signed_op` — input, 1 bit. 1 selects DIV (two's complement); 0 selects DIVU.
- `wide` — input, 1 bit.
  - 1: 32/16 division.
  - 0: 16/8 division.
- `dividend` — input, 32 bits.
  - Wide mode: the full DW:AW value.
  - Byte mode: only `[15:0]` (AW) is used; `[31:16]` is ignored.
- `divisor` — input, 16 bits. Byte mode uses only `[7:0]`.
- `busy` — output, 1 bit. High from the cycle after `start` is accepted until `done`.
- `done` — output, 1 bit. One-cycle pulse.
- `div_error` — output, 1 bit. Valid only with `done`.
- `quotient` — output, 16 bits. Byte mode: zero-extended from `[7:0]`.
- `remainder` — output, 16 bits. Byte mode: zero-extended from `[7:0]`.

## Operation
- **State machine.** States are IDLE, PREP, ITER, FIX, FINISH.
- **IDLE**
  - With `start`=1: latch `signed_op`, `wide`, `dividend`, `divisor`; go to PREP.
  - With `start`=0: stay in IDLE.
- **PREP**
  - Set N = 16 (wide) or 8 (byte).
  - Form magnitudes:
    - Dividend magnitude: 32-bit, or 16-bit in byte mode.
    - Divisor magnitude: N-bit.
    - Signed mode takes absolute values, computed unsigned, so 0x80000000 and 0x8000 are representable.
  - Record the quotient sign (dividend sign XOR divisor sign) and the remainder sign (dividend sign).
  - Go to FINISH with error if either holds:
    - divisor magnitude = 0;
    - upper N bits of the dividend magnitude ≥ divisor magnitude (quotient magnitude ≥ 2^N).
  - Otherwise load the partial remainder (N+1 bits) from the upper half, load the quotient shift register from the lower half, set the bit counter to N, and go to ITER.
- **ITER** (one step per cycle)
  - Shift {partial remainder, quotient} left by 1.
  - Trial-subtract the divisor magnitude.
  - If the result is non-negative, keep it and set quotient bit 0 to 1; otherwise restore.
  - Decrement the counter; go to FIX after the N-th step.
- **FIX**
  - Apply signs: negate the quotient if the quotient sign is 1; negate the remainder if the remainder sign is 1.
  - Signed range check on the final quotient: valid range is −2^(N−1)…2^(N−1)−1, so −128 and −32768 are accepted. Out of range means error.
  - Go to FINISH.
- **FINISH**
  - Pulse `done`; `div_error` = the error flag.
  - No error: update `quotient`/`remainder`.
  - Error: `quotient`/`remainder` keep their previous values.
  - Return to IDLE.
- **Arithmetic rules**
  - Quotient truncates toward zero.
  - The remainder takes the dividend's sign; |remainder| < |divisor|.
  - Unsigned mode skips the sign steps and the range check.
- **Boundary conditions**
  - `start` while `busy` is ignored and not queued.
  - `start` in the FINISH cycle is ignored; it is accepted the following cycle.
  - `reset` in any state gives IDLE next cycle with all outputs 0, regardless of operation in progress.
  - Operands are latched, so input changes after acceptance have no effect.

## Timing
- **Reset values:** `busy`=0, `done`=0, `div_error`=0, `quotient`=0x0000, `remainder`=0x0000, state IDLE.
- **Cycle numbering:** `start` is sampled high at the edge ending cycle 0.
- **Normal path**
  - PREP in cycle 1.
  - ITER in cycles 2…N+1.
  - FIX in cycle N+2.
  - `done` high in cycle N+3: cycle 19 (wide) or cycle 11 (byte).
- **Early error** (divide by zero or unsigned-magnitude overflow detected in PREP): `done`=1 and `div_error`=1 in cycle 2.
- **`busy`:** high in cycles 1 through N+2 (normal path) or cycle 1 only (early error); low in the `done` cycle.
- **Output registers:** `quotient`/`remainder` change only at the edge entering the `done` cycle, then hold until the next successful division or reset.
- **Throughput:** one division per N+4 cycles when back-to-back.

## Structure
- Add `div_state_e` (IDLE, PREP, ITER, FIX, FINISH) to the shared `types` package, next to `alu_operation_e`.
- Microcode opcode selection stays in the sequencer. It drives `signed_op`/`wide` directly, so no new `alu_operation_e` values are needed.
- Single module with one `always_ff` for state and datapath registers plus one `always_comb` for the trial subtract and next state. No sub-module is warranted.

## Test plan
1. Unsigned wide division, `dividend`=0x00010000, `divisor`=0x0002 → `done` in cycle 19, `quotient`=0x8000, `remainder`=0x0000, `div_error`=0.
2. Unsigned byte division, `dividend`=0x0064, `divisor`=0x07 → `done` in cycle 11, `quotient`=0x000E, `remainder`=0x0002.
3. Signed byte division, `dividend`=0xFFF9 (−7), `divisor`=0x02 → `quotient`=0x00FD, `remainder`=0x00FF. Signed wide division, 0xFFFF8000 / 0x0001 → `quotient`=0x8000, no error.
4. `divisor`=0 in both widths → `done` and `div_error` in cycle 2; `quotient`/`remainder` unchanged from the prior result.
5. Overflow cases:
   - Unsigned wide, 0x00020000 / 0x0002 → error in cycle 2.
   - Signed wide, 0x00008000 / 0x0001 → error in cycle 19.
   - Signed byte, 0x0080 / 0x01 → error in cycle 11.
6. Control cases:
   - `start` pulsed in cycle 5 of an active division → ignored; a single `done`.
   - `reset` asserted in cycle 8 → cycle 9 shows IDLE and all outputs 0; a new `start` then completes normally.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared definitions for the execute-stage divider.
//   div_state_e : divider sequencing states (IDLE, PREP, ITER, FIX, FINISH)
//   N_WIDE/N_BYTE : quotient widths for 32/16 and 16/8 division
package divider_pkg;

  typedef logic [2:0] div_state_e;

  localparam div_state_e IDLE   = 3'd0;
  localparam div_state_e PREP   = 3'd1;
  localparam div_state_e ITER   = 3'd2;
  localparam div_state_e FIX    = 3'd3;
  localparam div_state_e FINISH = 3'd4;

  localparam logic [4:0] N_WIDE = 5'd16;
  localparam logic [4:0] N_BYTE = 5'd8;

endpackage

// File: rtl/divider.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU, 32/16 and 16/8).
// One quotient bit per cycle; signs are stripped before iterating and
// re-applied afterwards, followed by a signed range check.
//   clk, reset  : clock, synchronous active-high reset
//   start       : request, sampled only in IDLE
//   signed_op   : 1 = two's complement (DIV), 0 = unsigned (DIVU)
//   wide        : 1 = 32/16, 0 = 16/8 (dividend[15:0], divisor[7:0])
//   dividend    : DW:AW (wide) or AW (byte)
//   divisor     : 16-bit divisor
//   busy        : operation in progress
//   done        : one-cycle completion pulse
//   div_error   : divide error, qualified by done
//   quotient    : result quotient (byte mode zero-extended)
//   remainder   : result remainder (byte mode zero-extended)
module divider
  import divider_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        signed_op,
  input  logic        wide,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        done,
  output logic        div_error,
  output logic [15:0] quotient,
  output logic [15:0] remainder
);

  div_state_e  state, state_next;

  logic        sgn_r;
  logic        wide_r;
  logic [31:0] dividend_r;
  logic [15:0] divisor_r;
  logic [15:0] dvs_mag_r;
  logic        q_sign;
  logic        r_sign;
  logic [16:0] prem;
  logic [15:0] qsr;
  logic [4:0]  cnt;

  logic        dvd_neg;
  logic        dvs_neg;
  logic [31:0] dvd_mag;
  logic [15:0] dvs_mag;
  logic [15:0] upper;
  logic [15:0] lower;
  logic        prep_err;
  logic [16:0] shifted;
  logic [17:0] trial;
  logic [15:0] q_mag;
  logic [15:0] q_half;
  logic [15:0] q_fix;
  logic [15:0] r_fix;
  logic        range_err;

  always_comb begin
    state_next = state;
    dvd_neg    = 1'b0;
    dvs_neg    = 1'b0;
    dvd_mag    = '0;
    dvs_mag    = '0;
    upper      = '0;
    lower      = '0;
    q_fix      = '0;
    r_fix      = '0;

    // Magnitudes are formed unsigned so the most negative operand
    // (0x80000000 / 0x8000) still has a representable absolute value.
    if (wide_r) begin
      dvd_neg = sgn_r & dividend_r[31];
      dvs_neg = sgn_r & divisor_r[15];
      dvd_mag = dvd_neg ? -dividend_r : dividend_r;
      dvs_mag = dvs_neg ? -divisor_r : divisor_r;
      upper   = dvd_mag[31:16];
      lower   = dvd_mag[15:0];
    end else begin
      dvd_neg = sgn_r & dividend_r[15];
      dvs_neg = sgn_r & divisor_r[7];
      dvd_mag = {16'b0, (dvd_neg ? -dividend_r[15:0] : dividend_r[15:0])};
      dvs_mag = {8'b0, (dvs_neg ? -divisor_r[7:0] : divisor_r[7:0])};
      upper   = {8'b0, dvd_mag[15:8]};
      lower   = {8'b0, dvd_mag[7:0]};
    end

    // Upper half >= divisor means the quotient needs more than N bits.
    prep_err = (dvs_mag == '0) || (upper >= dvs_mag);

    // Byte mode keeps its quotient in qsr[7:0], so the bit shifted into the
    // partial remainder comes from bit 7 rather than bit 15.
    shifted = {prem[15:0], (wide_r ? qsr[15] : qsr[7])};
    trial   = {1'b0, shifted} - {2'b0, dvs_mag_r};

    q_mag  = wide_r ? qsr : {8'b0, qsr[7:0]};
    q_half = wide_r ? 16'h8000 : 16'h0080;
    if (wide_r) begin
      q_fix = q_sign ? -q_mag : q_mag;
      r_fix = r_sign ? -prem[15:0] : prem[15:0];
    end else begin
      q_fix = {8'b0, (q_sign ? -qsr[7:0] : qsr[7:0])};
      r_fix = {8'b0, (r_sign ? -prem[7:0] : prem[7:0])};
    end
    // Negative results may reach -2^(N-1); positive ones stop at 2^(N-1)-1.
    range_err = sgn_r && (q_sign ? (q_mag > q_half) : (q_mag >= q_half));

    case (state)
      IDLE:    if (start) state_next = PREP;
      PREP:    state_next = prep_err ? FINISH : ITER;
      ITER:    if (cnt == 5'd1) state_next = FIX;
      FIX:     state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      div_error  <= 1'b0;
      quotient   <= '0;
      remainder  <= '0;
      sgn_r      <= 1'b0;
      wide_r     <= 1'b0;
      dividend_r <= '0;
      divisor_r  <= '0;
      dvs_mag_r  <= '0;
      q_sign     <= 1'b0;
      r_sign     <= 1'b0;
      prem       <= '0;
      qsr        <= '0;
      cnt        <= '0;
    end else begin
      state     <= state_next;
      done      <= 1'b0;
      div_error <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sgn_r      <= signed_op;
            wide_r     <= wide;
            dividend_r <= dividend;
            divisor_r  <= divisor;
            busy       <= 1'b1;
          end
        end
        PREP: begin
          q_sign    <= dvd_neg ^ dvs_neg;
          r_sign    <= dvd_neg;
          dvs_mag_r <= dvs_mag;
          prem      <= {1'b0, upper};
          qsr       <= lower;
          cnt       <= wide_r ? N_WIDE : N_BYTE;
          if (prep_err) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            div_error <= 1'b1;
          end
        end
        ITER: begin
          if (!trial[17]) begin
            prem <= trial[16:0];
            qsr  <= {qsr[14:0], 1'b1};
          end else begin
            prem <= shifted;
            qsr  <= {qsr[14:0], 1'b0};
          end
          cnt <= cnt - 5'd1;
        end
        FIX: begin
          busy      <= 1'b0;
          done      <= 1'b1;
          div_error <= range_err;
          if (!range_err) begin
            quotient  <= q_fix;
            remainder <= r_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
